// File: rtl/fp_div.sv
// Multi-cycle floating-point divider: restoring significand division, then normalise, then round.
// Defining FP_DIV_ROUND_EN selects round-to-nearest-even; otherwise the quotient is truncated.
module fp_div #(
   parameter int EXP_W  = 5,
   parameter int MANT_W = 10,
   localparam int W     = 1 + EXP_W + MANT_W
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         data_valid_in,
   output logic         ready_out,
   output logic [W-1:0] result,
   output logic         data_valid_out,
   output logic [3:0]   flags
);

   localparam int BIAS  = (2 ** (EXP_W - 1)) - 1;
   localparam int SIG_W = MANT_W + 1;
   localparam int QW    = MANT_W + 3;
   localparam int EW    = EXP_W + 2;
   localparam int CNT_W = $clog2(QW);

   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(QW - 1);
   localparam logic [EW-1:0]        BIAS_E   = EW'(BIAS);
   localparam logic signed [EW-1:0] EXP_MAX  = EW'((2 ** EXP_W) - 1);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_DIVIDING  = 2'd1;
   localparam logic [1:0] S_NORMALIZE = 2'd2;
   localparam logic [1:0] S_ROUND     = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [W-1:0]         a_q, a_d;
   logic [W-1:0]         b_q, b_d;
   logic [QW-1:0]        rem_q, rem_d;
   logic [QW-1:0]        quot_q, quot_d;
   logic [SIG_W-1:0]     mant_q, mant_d;
   logic signed [EW-1:0] exp_q, exp_d;
   logic                 guard_q, guard_d;
   logic                 sticky_q, sticky_d;
   logic                 ready_q, ready_d;
   logic                 valid_q, valid_d;
   logic [W-1:0]         result_q, result_d;
   logic [3:0]           flags_q, flags_d;

   logic                 accept;
   logic [QW-1:0]        divisor;
   logic signed [EW-1:0] exp_base;
   logic                 round_up;
   logic [SIG_W:0]       mant_sum;
   logic signed [EW-1:0] exp_fin;
   logic [MANT_W-1:0]    frac_fin;
   logic                 overflow;
   logic                 underflow;

   logic [EXP_W-1:0]     a_exp, b_exp;
   logic [MANT_W-1:0]    a_frac, b_frac;
   logic                 a_nan, a_inf, a_zero;
   logic                 b_nan, b_inf, b_zero;
   logic                 sign_r;
   logic [W-1:0]         inf_r, zero_r, qnan_r;

   assign accept = data_valid_in && ready_q;

   assign a_exp  = a_q[W-2:MANT_W];
   assign b_exp  = b_q[W-2:MANT_W];
   assign a_frac = a_q[MANT_W-1:0];
   assign b_frac = b_q[MANT_W-1:0];

   // Subnormal operands have no hidden bit here and are treated as zero.
   assign a_nan  = (&a_exp) && (|a_frac);
   assign a_inf  = (&a_exp) && !(|a_frac);
   assign a_zero = !(|a_exp);
   assign b_nan  = (&b_exp) && (|b_frac);
   assign b_inf  = (&b_exp) && !(|b_frac);
   assign b_zero = !(|b_exp);

   assign sign_r = a_q[W-1] ^ b_q[W-1];
   assign inf_r  = {sign_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
   assign zero_r = {sign_r, {(W-1){1'b0}}};
   assign qnan_r = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

   assign divisor  = {2'b00, 1'b1, b_frac};
   assign exp_base = {2'b00, a_exp} - {2'b00, b_exp} + BIAS_E;

`ifdef FP_DIV_ROUND_EN
   assign round_up = guard_q && (sticky_q || mant_q[0]);
`else
   logic unused_grs;
   assign round_up   = 1'b0;
   assign unused_grs = guard_q ^ sticky_q;
`endif

   // A carry out of the significand means the value became 2.0: shift right and bump the exponent.
   assign mant_sum  = {1'b0, mant_q} + {{SIG_W{1'b0}}, round_up};
   assign exp_fin   = mant_sum[SIG_W] ? (exp_q + EW'(1)) : exp_q;
   assign frac_fin  = mant_sum[SIG_W] ? mant_sum[MANT_W:1] : mant_sum[MANT_W-1:0];
   assign overflow  = !exp_fin[EW-1] && (exp_fin >= EXP_MAX);
   assign underflow = exp_fin[EW-1] || (exp_fin == '0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      mant_d   = mant_q;
      exp_d    = exp_q;
      guard_d  = guard_q;
      sticky_d = sticky_q;
      ready_d  = ready_q;
      valid_d  = 1'b0;
      result_d = result_q;
      flags_d  = flags_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_d     = a;
               b_d     = b;
               rem_d   = {2'b00, 1'b1, a[MANT_W-1:0]};
               quot_d  = '0;
               cnt_d   = '0;
               ready_d = 1'b0;
               state_d = S_DIVIDING;
            end
         end

         S_DIVIDING: begin
            if (rem_q >= divisor) begin
               rem_d  = (rem_q - divisor) << 1;
               quot_d = {quot_q[QW-2:0], 1'b1};
            end else begin
               rem_d  = rem_q << 1;
               quot_d = {quot_q[QW-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_NORMALIZE;
            end
         end

         // Quotient lies in [0.5, 2): either the top bit is the integer bit or the next one is.
         S_NORMALIZE: begin
            if (quot_q[QW-1]) begin
               mant_d   = quot_q[QW-1:2];
               guard_d  = quot_q[1];
               sticky_d = quot_q[0] || (|rem_q);
               exp_d    = exp_base;
            end else begin
               mant_d   = quot_q[QW-2:1];
               guard_d  = quot_q[0];
               sticky_d = |rem_q;
               exp_d    = exp_base - EW'(1);
            end
            state_d = S_ROUND;
         end

         S_ROUND: begin
            valid_d = 1'b1;
            ready_d = 1'b1;
            state_d = S_IDLE;
            flags_d = 4'b0000;
            if (a_nan || b_nan) begin
               result_d = qnan_r;
            end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
               result_d = qnan_r;
               flags_d  = 4'b1000;
            end else if (a_inf) begin
               result_d = inf_r;
            end else if (b_zero) begin
               result_d = inf_r;
               flags_d  = 4'b0100;
            end else if (a_zero || b_inf) begin
               result_d = zero_r;
            end else if (overflow) begin
               result_d = inf_r;
               flags_d  = 4'b0010;
            end else if (underflow) begin
               result_d = zero_r;
               flags_d  = 4'b0001;
            end else begin
               result_d = {sign_r, exp_fin[EXP_W-1:0], frac_fin};
            end
         end

         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         mant_q   <= '0;
         exp_q    <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         mant_q   <= mant_d;
         exp_q    <= exp_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign ready_out      = ready_q;
   assign data_valid_out = valid_q;
   assign result         = result_q;
   assign flags          = flags_q;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed vectors, handshake/reset scenarios and
// randomized operands compared against an integer-arithmetic reference model.
module tb_fp_div;

   localparam int EXP_W   = 5;
   localparam int MANT_W  = 10;
   localparam int W       = 16;
   localparam int LATENCY = MANT_W + 5;

   logic         clk_in = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         data_valid_in = 1'b0;
   logic         ready_out;
   logic [W-1:0] result;
   logic         data_valid_out;
   logic [3:0]   flags;

   int compared   = 0;
   int mismatched = 0;

   fp_div #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
      .clk_in         (clk_in),
      .rst            (rst),
      .a              (a),
      .b              (b),
      .data_valid_in  (data_valid_in),
      .ready_out      (ready_out),
      .result         (result),
      .data_valid_out (data_valid_out),
      .flags          (flags)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // Reference: quotient computed as an integer division of the scaled significands,
   // rounded by comparing twice the remainder against the divisor.
   function automatic logic [19:0] refDiv(input logic [15:0] x, input logic [15:0] y);
      int  ex, ey, fx, fy, ma, mb, num, e, t;
      bit  sg, xnan, xinf, xzero, ynan, yinf, yzero;
      ex = int'(x[14:10]);
      ey = int'(y[14:10]);
      fx = int'(x[9:0]);
      fy = int'(y[9:0]);
      sg = x[15] ^ y[15];
      xnan  = (ex == 31) && (fx != 0);
      xinf  = (ex == 31) && (fx == 0);
      xzero = (ex == 0);
      ynan  = (ey == 31) && (fy != 0);
      yinf  = (ey == 31) && (fy == 0);
      yzero = (ey == 0);
      if (xnan || ynan) return {4'b0000, 16'h7E00};
      if ((xzero && yzero) || (xinf && yinf)) return {4'b1000, 16'h7E00};
      if (xinf) return {4'b0000, sg, 15'h7C00};
      if (yzero) return {4'b0100, sg, 15'h7C00};
      if (xzero || yinf) return {4'b0000, sg, 15'h0000};
      ma  = 1024 + fx;
      mb  = 1024 + fy;
      e   = ex - ey + 15;
      num = ma;
      if (ma < mb) begin
         num = 2 * ma;
         e   = e - 1;
      end
      t = (num * 1024) / mb;
`ifdef FP_DIV_ROUND_EN
      begin
         int r;
         r = (num * 1024) % mb;
         if ((2 * r > mb) || ((2 * r == mb) && (t % 2 == 1))) t = t + 1;
         if (t == 2048) begin
            t = 1024;
            e = e + 1;
         end
      end
`endif
      if (e >= 31) return {4'b0010, sg, 15'h7C00};
      if (e <= 0) return {4'b0001, sg, 15'h0000};
      return {4'b0000, sg, 5'(e), 10'(t)};
   endfunction

   // Called #1 after a rising edge; returns #1 after the edge on which the pulse is seen.
   task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb_,
                                output logic [15:0] res, output logic [3:0] fl, output int lat);
      int waited;
      waited = 0;
      while (!ready_out && waited < 100) begin
         @(posedge clk_in);
         #1;
         waited++;
      end
      if (!ready_out) checkOutput("ready_timeout", 32'(ready_out), 32'd1);
      a = ta;
      b = tb_;
      data_valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      data_valid_in = 1'b0;
      checkOutput("ready_drop", 32'(ready_out), 32'd0);
      lat = 0;
      res = '0;
      fl  = '0;
      do begin
         @(posedge clk_in);
         #1;
         lat++;
      end while (!data_valid_out && lat < 100);
      if (data_valid_out) begin
         res = result;
         fl  = flags;
         checkOutput("ready_rise", 32'(ready_out), 32'd1);
      end
   endtask

   task automatic doOp(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic [15:0] want_res, input logic [3:0] want_fl);
      logic [15:0] res;
      logic [3:0]  fl;
      int          lat;
      applyStimulus(ta, tb_, res, fl, lat);
      checkOutput({tag, "_res"}, 32'(res), 32'(want_res));
      checkOutput({tag, "_flags"}, 32'(fl), 32'(want_fl));
      checkOutput({tag, "_lat"}, 32'(lat), 32'(LATENCY));
   endtask

   task automatic countPulses(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk_in);
         #1;
         if (data_valid_out) n++;
      end
   endtask

   initial begin
      logic [15:0] ra, rb, exp_q3b;
      logic [19:0] want;
      int          pulses, first_pulse;

      repeat (3) @(posedge clk_in);
      #1;
      checkOutput("rst_ready", 32'(ready_out), 32'd1);
      checkOutput("rst_valid", 32'(data_valid_out), 32'd0);
      checkOutput("rst_result", 32'(result), 32'd0);
      checkOutput("rst_flags", 32'(flags), 32'd0);
      rst = 1'b0;
      @(posedge clk_in);
      #1;

      doOp("one_div_one", 16'h3C00, 16'h3C00, 16'h3C00, 4'b0000);
      @(posedge clk_in);
      #1;
      checkOutput("pulse_width", 32'(data_valid_out), 32'd0);
      checkOutput("hold_result", 32'(result), 32'h3C00);

`ifdef FP_DIV_ROUND_EN
      exp_q3b = 16'h3B88;
`else
      exp_q3b = 16'h3B87;
`endif
      doOp("round_case", 16'h3C00, 16'h3C40, exp_q3b, 4'b0000);
      doOp("neg_two", 16'hC000, 16'h4000, 16'hBC00, 4'b0000);
      doOp("div_zero", 16'h3C00, 16'h0000, 16'h7C00, 4'b0100);
      doOp("zero_zero", 16'h0000, 16'h0000, 16'h7E00, 4'b1000);
      doOp("nan_in", 16'h7E00, 16'h3C00, 16'h7E00, 4'b0000);
      doOp("overflow", 16'h7BFF, 16'h0400, 16'h7C00, 4'b0010);
      doOp("underflow", 16'h0400, 16'h7BFF, 16'h0000, 4'b0001);
      doOp("inf_inf", 16'hFC00, 16'h7C00, 16'h7E00, 4'b1000);
      doOp("fin_inf", 16'hC500, 16'h7C00, 16'h8000, 4'b0000);

      // Spurious data_valid_in while busy must be ignored.
      a = 16'h3C00;
      b = 16'h4000;
      data_valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      data_valid_in = 1'b0;
      pulses = 0;
      first_pulse = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 3) begin
            a = 16'h4000;
            b = 16'h3C00;
            data_valid_in = 1'b1;
         end
         @(posedge clk_in);
         #1;
         data_valid_in = 1'b0;
         if (data_valid_out) begin
            pulses++;
            if (first_pulse == 0) begin
               first_pulse = i;
               checkOutput("busy_res", 32'(result), 32'h3800);
            end
         end
      end
      checkOutput("busy_pulses", 32'(pulses), 32'd1);
      checkOutput("busy_lat", 32'(first_pulse), 32'(LATENCY));

      // Reset mid-operation aborts it.
      a = 16'h3C00;
      b = 16'h3C40;
      data_valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      data_valid_in = 1'b0;
      repeat (4) @(posedge clk_in);
      #1;
      rst = 1'b1;
      @(posedge clk_in);
      #1;
      rst = 1'b0;
      checkOutput("abort_ready", 32'(ready_out), 32'd1);
      checkOutput("abort_result", 32'(result), 32'd0);
      checkOutput("abort_flags", 32'(flags), 32'd0);
      countPulses(30, pulses);
      checkOutput("abort_pulses", 32'(pulses), 32'd0);

      // Reset wins over a simultaneous request.
      a = 16'h3C00;
      b = 16'h3C00;
      rst = 1'b1;
      data_valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      rst = 1'b0;
      data_valid_in = 1'b0;
      checkOutput("rst_prio_ready", 32'(ready_out), 32'd1);
      countPulses(25, pulses);
      checkOutput("rst_prio_pulses", 32'(pulses), 32'd0);

      doOp("after_abort", 16'h4200, 16'h4000, 16'h3E00, 4'b0000);

      for (int n = 0; n < 200; n++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(0, 65535));
         if (n % 8 == 0) rb[14:10] = ra[14:10];
         want = refDiv(ra, rb);
         doOp($sformatf("rand%0d_%04h_%04h", n, ra, rb), ra, rb, want[15:0], want[19:16]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
